serial_nibble_receiver: RTL and testbench

Serial-to-parallel front end for the 4-bit combinational datapath (adders, subtractors, adder-subtractor, comparator, parity generator). It receives framed serial nibbles on a single line, samples each bit mid-period, checks the parity bit, and presents each 4-bit word with error flags through a one-entry valid/ready output register. The downstream 4-bit arithmetic and compare stages consume `data_out`.

---
 rtl/serial_nibble_receiver_if.sv | 33 +++
 rtl/serial_nibble_receiver.sv | 153 +++++++++++++++
 tb/tb_serial_nibble_receiver.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_nibble_receiver_if.sv
// Serial nibble receiver port bundle: serial line in, held word and status out.
interface serial_nibble_receiver_if;
  logic       rx;
  logic       ready;
  logic [3:0] data_out;
  logic       valid;
  logic       par_err;
  logic       frm_err;
  logic       overrun;
  logic       busy;

  modport master (
    input  rx,
    input  ready,
    output data_out,
    output valid,
    output par_err,
    output frm_err,
    output overrun,
    output busy
  );

  modport slave (
    output rx,
    output ready,
    input  data_out,
    input  valid,
    input  par_err,
    input  frm_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/serial_nibble_receiver.sv
// Framed serial nibble receiver: mid-bit sampling, parity/stop checking and a
// one-entry valid/ready output register feeding the 4-bit datapath.
module serial_nibble_receiver #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          ODD_PARITY   = 1'b0
) (
  input logic                      clk,
  input logic                      rst_n,
  serial_nibble_receiver_if.master bus
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_WAIT_HIGH = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_PARITY    = 3'd4;
  localparam logic [2:0] S_STOP      = 3'd5;

  logic [2:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [1:0]       bit_q,     bit_d;
  logic [3:0]       shift_q,   shift_d;
  logic             par_q,     par_d;
  logic [3:0]       data_q,    data_d;
  logic             valid_q,   valid_d;
  logic             perr_q,    perr_d;
  logic             ferr_q,    ferr_d;
  logic             overrun_q, overrun_d;
  logic             busy_q,    busy_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_WAIT_HIGH;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, bit sampling and delivery
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    overrun_d = 1'b0;

    if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_WAIT_HIGH: begin
        if (bus.rx) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!bus.rx) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = bus.rx ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          // LSB arrives first, so shifting in from the top leaves d0 at bit 0
          shift_d = {bus.rx, shift_q[3:1]};
          if (bit_q == 2'd3) state_d = S_PARITY;
          else               bit_d   = bit_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          par_d   = bus.rx;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          // A word drained on this same edge frees the register for the new one
          if (!valid_q || bus.ready) begin
            data_d  = shift_q;
            perr_d  = ((^shift_q) ^ par_q) != ODD_PARITY;
            ferr_d  = !bus.rx;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
          state_d = bus.rx ? S_IDLE : S_WAIT_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_WAIT_HIGH;
    endcase

    busy_d = (state_d == S_START) || (state_d == S_DATA) ||
             (state_d == S_PARITY) || (state_d == S_STOP);
  end

  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign bus.par_err  = perr_q;
  assign bus.frm_err  = ferr_q;
  assign bus.overrun  = overrun_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_serial_nibble_receiver.sv
// Bench for serial_nibble_receiver: directed scenarios plus randomized frames
// checked against a word-level scoreboard of the output register.
module tb_serial_nibble_receiver;

  localparam int unsigned N   = 4;
  localparam bit          ODD = 1'b0;

  logic clk = 1'b0;
  logic rst_n;
  int   checks  = 0;
  int   passed  = 0;
  int   ov_seen = 0;

  always #5 clk = ~clk;

  serial_nibble_receiver_if bus ();

  serial_nibble_receiver #(
    .CLKS_PER_BIT(N),
    .ODD_PARITY  (ODD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always @(negedge clk) if (bus.overrun === 1'b1) ov_seen++;

  function automatic logic good_par(input logic [3:0] d);
    return (^d) ^ ODD;
  endfunction

  function automatic logic exp_perr(input logic [3:0] d, input logic p);
    return logic'(((^d) ^ p) != ODD);
  endfunction

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bus.rx = 1'b1;
      @(negedge clk);
    end
  endtask

  // Sends one frame from the idle/stop state; returns just after the stop-sample
  // edge with the stop level still on the line. v_pre/b_pre are valid/busy one
  // cycle before the stop sample.
  task automatic drive_frame(input logic [3:0] d, input logic p, input logic stop,
                             input bit ready_at_stop, output logic v_pre, output logic b_pre);
    logic [6:0] bits;
    bits = {stop, p, d, 1'b0};
    for (int b = 0; b < 6; b++) begin
      for (int c = 0; c < int'(N); c++) begin
        bus.rx = bits[b];
        @(negedge clk);
      end
    end
    v_pre = 1'b0;
    b_pre = 1'b0;
    for (int c = 0; c <= int'(N / 2); c++) begin
      bus.rx = stop;
      if (c == int'(N / 2)) begin
        v_pre = bus.valid;
        b_pre = bus.busy;
        if (ready_at_stop) bus.ready = 1'b1;
      end
      @(negedge clk);
    end
    if (ready_at_stop) bus.ready = 1'b0;
  endtask

  task automatic drain();
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.rx    = 1'b0;
    bus.ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.data_out !== 4'd0) $display("FAIL reset_data: got %h want 0", bus.data_out); else passed++;
    checks++; if (bus.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.valid); else passed++;
    checks++; if (bus.par_err !== 1'b0) $display("FAIL reset_par_err: got %b want 0", bus.par_err); else passed++;
    checks++; if (bus.frm_err !== 1'b0) $display("FAIL reset_frm_err: got %b want 0", bus.frm_err); else passed++;
    checks++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", bus.overrun); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    rst_n = 1'b1;
    // Line still low after reset must not start a frame
    repeat (6) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_low_line_busy: got %b want 0", bus.busy); else passed++;
    idle(3);
  endtask

  task automatic test_good_frame();
    logic v_pre, b_pre;
    drive_frame(4'b0101, 1'b0, 1'b1, 1'b0, v_pre, b_pre);
    checks++; if (v_pre !== 1'b0) $display("FAIL good_valid_early: got %b want 0", v_pre); else passed++;
    checks++; if (b_pre !== 1'b1) $display("FAIL good_busy_in_frame: got %b want 1", b_pre); else passed++;
    checks++; if (bus.valid !== 1'b1) $display("FAIL good_valid: got %b want 1", bus.valid); else passed++;
    checks++; if (bus.data_out !== 4'b0101) $display("FAIL good_data: got %b want 0101", bus.data_out); else passed++;
    checks++; if (bus.par_err !== 1'b0) $display("FAIL good_par_err: got %b want 0", bus.par_err); else passed++;
    checks++; if (bus.frm_err !== 1'b0) $display("FAIL good_frm_err: got %b want 0", bus.frm_err); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL good_busy_after: got %b want 0", bus.busy); else passed++;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.valid !== 1'b1) $display("FAIL good_valid_held: got %b want 1", bus.valid); else passed++;
    drain();
    checks++; if (bus.valid !== 1'b0) $display("FAIL good_valid_drop: got %b want 0", bus.valid); else passed++;
    idle(2);
  endtask

  task automatic test_parity_error();
    logic v_pre, b_pre;
    drive_frame(4'b0111, 1'b0, 1'b1, 1'b0, v_pre, b_pre);
    checks++; if (bus.data_out !== 4'b0111) $display("FAIL perr_data: got %b want 0111", bus.data_out); else passed++;
    checks++; if (bus.par_err !== 1'b1) $display("FAIL perr_flag: got %b want 1", bus.par_err); else passed++;
    checks++; if (bus.frm_err !== 1'b0) $display("FAIL perr_frm_err: got %b want 0", bus.frm_err); else passed++;
    bus.rx = 1'b1;
    drain();
    idle(2);
  endtask

  task automatic test_framing_error();
    logic v_pre, b_pre;
    logic busy_seen;
    drive_frame(4'b0011, good_par(4'b0011), 1'b0, 1'b0, v_pre, b_pre);
    checks++; if (bus.frm_err !== 1'b1) $display("FAIL ferr_flag: got %b want 1", bus.frm_err); else passed++;
    checks++; if (bus.par_err !== 1'b0) $display("FAIL ferr_par_err: got %b want 0", bus.par_err); else passed++;
    checks++; if (bus.data_out !== 4'b0011) $display("FAIL ferr_data: got %b want 0011", bus.data_out); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL ferr_busy: got %b want 0", bus.busy); else passed++;
    busy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.rx = 1'b0;
      @(negedge clk);
      if (bus.busy !== 1'b0) busy_seen = 1'b1;
    end
    checks++; if (busy_seen !== 1'b0) $display("FAIL ferr_line_low_start: got %b want 0", busy_seen); else passed++;
    idle(2);
    drain();
    drive_frame(4'b1000, good_par(4'b1000), 1'b1, 1'b0, v_pre, b_pre);
    checks++; if (bus.data_out !== 4'b1000) $display("FAIL ferr_next_data: got %b want 1000", bus.data_out); else passed++;
    checks++; if ({bus.valid, bus.par_err, bus.frm_err} !== 3'b100)
      $display("FAIL ferr_next_flags: got %b want 100", {bus.valid, bus.par_err, bus.frm_err}); else passed++;
    bus.rx = 1'b1;
    drain();
    idle(2);
  endtask

  task automatic test_glitch_overrun();
    logic v_pre, b_pre;
    int   ov0;
    bus.rx = 1'b0;
    @(negedge clk);
    bus.rx = 1'b1;
    checks++; if (bus.busy !== 1'b1) $display("FAIL glitch_busy_e0: got %b want 1", bus.busy); else passed++;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) $display("FAIL glitch_busy_e1: got %b want 1", bus.busy); else passed++;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("FAIL glitch_busy_e2: got %b want 0", bus.busy); else passed++;
    idle(3);
    checks++; if (bus.valid !== 1'b0) $display("FAIL glitch_valid: got %b want 0", bus.valid); else passed++;

    bus.ready = 1'b0;
    drive_frame(4'b1010, good_par(4'b1010), 1'b1, 1'b0, v_pre, b_pre);
    checks++; if (bus.data_out !== 4'b1010) $display("FAIL ovr_first_data: got %b want 1010", bus.data_out); else passed++;
    ov0 = ov_seen;
    drive_frame(4'b0110, good_par(4'b0110), 1'b1, 1'b0, v_pre, b_pre);
    checks++; if (bus.overrun !== 1'b1) $display("FAIL ovr_pulse: got %b want 1", bus.overrun); else passed++;
    checks++; if (bus.data_out !== 4'b1010) $display("FAIL ovr_data_kept: got %b want 1010", bus.data_out); else passed++;
    bus.rx = 1'b1;
    @(negedge clk);
    checks++; if (bus.overrun !== 1'b0) $display("FAIL ovr_pulse_width: got %b want 0", bus.overrun); else passed++;
    idle(2);
    checks++; if (ov_seen - ov0 !== 1) $display("FAIL ovr_count: got %0d want 1", ov_seen - ov0); else passed++;
  endtask

  task automatic test_simultaneous();
    logic v_pre, b_pre;
    drive_frame(4'b0110, good_par(4'b0110), 1'b1, 1'b1, v_pre, b_pre);
    checks++; if (v_pre !== 1'b1) $display("FAIL simul_valid_before: got %b want 1", v_pre); else passed++;
    checks++; if (bus.overrun !== 1'b0) $display("FAIL simul_overrun: got %b want 0", bus.overrun); else passed++;
    checks++; if (bus.data_out !== 4'b0110) $display("FAIL simul_data: got %b want 0110", bus.data_out); else passed++;
    checks++; if (bus.valid !== 1'b1) $display("FAIL simul_valid: got %b want 1", bus.valid); else passed++;
    bus.rx = 1'b1;
    drain();
    idle(2);
  endtask

  task automatic test_reset_midframe();
    logic v_pre, b_pre;
    logic valid_seen;
    drive_frame(4'b0101, good_par(4'b0101), 1'b1, 1'b0, v_pre, b_pre);
    bus.rx = 1'b1;
    @(negedge clk);
    // Start, d0=1, d1=1, then reset during d2 while the line is low
    for (int c = 0; c < int'(N); c++) begin bus.rx = 1'b0; @(negedge clk); end
    for (int c = 0; c < int'(2 * N); c++) begin bus.rx = 1'b1; @(negedge clk); end
    bus.rx = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({bus.data_out, bus.valid, bus.par_err, bus.frm_err, bus.overrun, bus.busy} !== 9'd0)
      $display("FAIL rst_mid_outputs: got %b want 000000000",
               {bus.data_out, bus.valid, bus.par_err, bus.frm_err, bus.overrun, bus.busy}); else passed++;
    valid_seen = 1'b0;
    for (int c = 0; c < int'(N) - 2; c++) begin
      bus.rx = 1'b0; @(negedge clk);
      if (bus.valid !== 1'b0 || bus.busy !== 1'b0) valid_seen = 1'b1;
    end
    // Remainder of the interrupted frame: d3=1, parity=1, stop=1, then idle
    for (int c = 0; c < int'(3 * N) + 4; c++) begin
      bus.rx = 1'b1; @(negedge clk);
      if (bus.valid !== 1'b0) valid_seen = 1'b1;
    end
    checks++; if (valid_seen !== 1'b0) $display("FAIL rst_mid_ghost_word: got %b want 0", valid_seen); else passed++;
    drive_frame(4'b1111, 1'b0, 1'b1, 1'b0, v_pre, b_pre);
    checks++; if (bus.data_out !== 4'b1111) $display("FAIL rst_mid_data: got %b want 1111", bus.data_out); else passed++;
    checks++; if (bus.par_err !== 1'b0) $display("FAIL rst_mid_par_err: got %b want 0", bus.par_err); else passed++;
    checks++; if (bus.valid !== 1'b1) $display("FAIL rst_mid_valid: got %b want 1", bus.valid); else passed++;
    bus.rx = 1'b1;
    drain();
    idle(2);
  endtask

  // Randomized frames against a word-level model of the one-entry output register
  task automatic test_random_frames();
    logic [3:0] d;
    logic       p, stop, r_new, r_old, v_pre, b_pre;
    logic       m_valid, m_perr, m_ferr, m_ovr;
    logic [3:0] m_data;
    int         gap;
    bus.rx    = 1'b1;
    bus.ready = 1'b1;
    repeat (2) @(negedge clk);
    m_valid = 1'b0;
    m_data  = bus.data_out;
    m_perr  = bus.par_err;
    m_ferr  = bus.frm_err;
    r_old   = 1'b1;
    stop    = 1'b1;
    for (int i = 0; i < 12; i++) begin
      gap = $urandom_range(0, 3);
      if (!stop && gap == 0) gap = 1;
      for (int g = 0; g < gap; g++) begin bus.rx = 1'b1; @(negedge clk); end
      d     = 4'($urandom_range(0, 15));
      p     = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
      stop  = ($urandom_range(0, 3) != 0);
      r_new = 1'($urandom_range(0, 1));
      if (r_new || (r_old && gap > 0)) m_valid = 1'b0;
      bus.ready = r_new;
      drive_frame(d, p, stop, 1'b0, v_pre, b_pre);
      m_ovr = 1'b0;
      if (!m_valid || r_new) begin
        m_data  = d;
        m_perr  = exp_perr(d, p);
        m_ferr  = ~stop;
      end else begin
        m_ovr = 1'b1;
      end
      checks++; if (v_pre !== (m_valid && !r_new ? 1'b1 : m_valid))
        $display("FAIL rand%0d_valid_before: got %b want %b", i, v_pre, m_valid); else passed++;
      checks++; if (bus.valid !== 1'b1) $display("FAIL rand%0d_valid: got %b want 1", i, bus.valid); else passed++;
      checks++; if (bus.data_out !== m_data) $display("FAIL rand%0d_data: got %b want %b", i, bus.data_out, m_data); else passed++;
      checks++; if (bus.par_err !== m_perr) $display("FAIL rand%0d_par_err: got %b want %b", i, bus.par_err, m_perr); else passed++;
      checks++; if (bus.frm_err !== m_ferr) $display("FAIL rand%0d_frm_err: got %b want %b", i, bus.frm_err, m_ferr); else passed++;
      checks++; if (bus.overrun !== m_ovr) $display("FAIL rand%0d_overrun: got %b want %b", i, bus.overrun, m_ovr); else passed++;
      m_valid = 1'b1;
      r_old   = r_new;
    end
    bus.rx    = 1'b1;
    bus.ready = 1'b0;
    idle(2);
    drain();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_framing_error();
    test_glitch_overrun();
    test_simultaneous();
    test_reset_midframe();
    test_random_frames();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
